// File: rtl/param_password_lock.sv
// Purpose: parametrised serial password lock (validate / set / lockdown with admin release).
// Latency: lights and counters update 1 cycle after the strobe edge that accepts a digit.
// Backpressure: none; one digit accepted per digitValid cycle, strobes coincident with clear are dropped.
// Optional feature macro: LOCKOUT_TIMER_EN (auto-release from lockdown after LOCKOUT_CYCLES cycles).
module param_password_lock #(
    parameter int unsigned              DIGIT_W        = 4,
    parameter int unsigned              LEN            = 4,
    parameter int unsigned              MAX_FAILS      = 3,
    parameter logic [LEN*DIGIT_W-1:0]   INIT_PW        = '0,
    parameter logic [LEN*DIGIT_W-1:0]   ADMIN_PW       = 16'h0129,
    parameter int unsigned              LOCKOUT_CYCLES = 1000
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             setMode,
    input  logic                             digitValid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             clear,
    output logic                             unlockLight,
    output logic                             errorLight,
    output logic                             warningLight,
    output logic [$clog2(MAX_FAILS+1)-1:0]   failCount,
    output logic [$clog2(LEN+1)-1:0]         entryIndex
);

    localparam int unsigned PW_W = LEN * DIGIT_W;
    localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
    localparam int unsigned IW   = $clog2(LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTER    = 3'd1,
        S_ERROR    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_SET      = 3'd4,
        S_LOCKED   = 3'd5
    } state_t;

    state_t            r_state;
    logic [PW_W-1:0]   r_pw;
    logic [PW_W-1:0]   r_shadow;
    logic              r_mismatch;
    logic [IW-1:0]     r_idx;
    logic [FW-1:0]     r_fail;

    state_t            w_state_nxt;
    logic [PW_W-1:0]   w_pw_nxt;
    logic [PW_W-1:0]   w_shadow_nxt;
    logic              w_mismatch_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic [FW-1:0]     w_fail_nxt;

    logic              w_last;
    logic              w_mm;
    logic [FW-1:0]     w_fail_inc;
    logic [PW_W-1:0]   w_shadow_put;
    logic              w_timer_done;

    // Digit k lives in the slot counted from the MS end, so the first digit typed is the top slot.
    function automatic logic [DIGIT_W-1:0] f_slot(input logic [PW_W-1:0] v, input logic [IW-1:0] k);
        f_slot = '0;
        for (int j = 0; j < LEN; j++) begin
            if (k == IW'(j)) begin
                f_slot = v[(LEN-1-j)*DIGIT_W +: DIGIT_W];
            end
        end
    endfunction

    function automatic logic [PW_W-1:0] f_put(input logic [PW_W-1:0] v, input logic [IW-1:0] k,
                                              input logic [DIGIT_W-1:0] d);
        f_put = v;
        for (int j = 0; j < LEN; j++) begin
            if (k == IW'(j)) begin
                f_put[(LEN-1-j)*DIGIT_W +: DIGIT_W] = d;
            end
        end
    endfunction

`ifdef LOCKOUT_TIMER_EN
    localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;

    // The final locked cycle is the one where the counter shows LOCKOUT_CYCLES-1; its closing edge releases.
    assign w_timer_done = (r_state == S_LOCKED) && (r_timer == TW'(LOCKOUT_CYCLES - 1));

    // Count cycles spent in lockdown; any exit (admin, timer, reset) restarts from zero.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_timer <= '0;
        end else if ((r_state == S_LOCKED) && (w_state_nxt == S_LOCKED)) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= '0;
        end
    end
`else
    assign w_timer_done = 1'b0;
`endif

    // State and datapath registers; reset discards any partial entry or shadow.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_pw       <= INIT_PW;
            r_shadow   <= '0;
            r_mismatch <= 1'b0;
            r_idx      <= '0;
            r_fail     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pw       <= w_pw_nxt;
            r_shadow   <= w_shadow_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_idx      <= w_idx_nxt;
            r_fail     <= w_fail_nxt;
        end
    end

    // Next-state and datapath update; clear outranks a coincident strobe everywhere.
    always_comb begin
        w_state_nxt    = r_state;
        w_pw_nxt       = r_pw;
        w_shadow_nxt   = r_shadow;
        w_mismatch_nxt = r_mismatch;
        w_idx_nxt      = r_idx;
        w_fail_nxt     = r_fail;

        // idx is 0 in every state that starts a sequence, so one index serves all paths.
        w_last       = (r_idx == IW'(LEN - 1));
        w_mm         = ((r_state == S_ENTER) && r_mismatch) || (digit != f_slot(r_pw, r_idx));
        w_fail_inc   = (r_fail == FW'(MAX_FAILS)) ? r_fail : r_fail + FW'(1);
        w_shadow_put = f_put(r_shadow, r_idx, digit);

        case (r_state)
            S_IDLE, S_ERROR, S_ENTER: begin
                if (clear) begin
                    w_state_nxt    = S_IDLE;
                    w_idx_nxt      = '0;
                    w_mismatch_nxt = 1'b0;
                end else if (digitValid) begin
                    if (w_last) begin
                        w_idx_nxt      = '0;
                        w_mismatch_nxt = 1'b0;
                        if (!w_mm) begin
                            w_state_nxt = S_UNLOCKED;
                            w_fail_nxt  = '0;
                        end else begin
                            w_fail_nxt  = w_fail_inc;
                            w_state_nxt = (w_fail_inc == FW'(MAX_FAILS)) ? S_LOCKED : S_ERROR;
                        end
                    end else begin
                        w_state_nxt    = S_ENTER;
                        w_idx_nxt      = r_idx + IW'(1);
                        w_mismatch_nxt = w_mm;
                    end
                end
            end
            S_UNLOCKED, S_SET: begin
                if (clear) begin
                    w_state_nxt = (r_state == S_SET) ? S_UNLOCKED : S_IDLE;
                    w_idx_nxt   = '0;
                end else if (digitValid && ((r_state == S_SET) || setMode)) begin
                    if (w_last) begin
                        // Commit the whole new password in one edge, including this final digit.
                        w_pw_nxt    = w_shadow_put;
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_shadow_nxt = w_shadow_put;
                        w_state_nxt  = S_SET;
                        w_idx_nxt    = r_idx + IW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (w_timer_done) begin
                    w_state_nxt = S_IDLE;
                    w_fail_nxt  = '0;
                    w_idx_nxt   = '0;
                end else if (digitValid && !clear) begin
                    if (digit == f_slot(ADMIN_PW, r_idx)) begin
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                            w_fail_nxt  = '0;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else begin
                        // A wrong digit restarts the admin sequence without being reused as its first digit.
                        w_idx_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Moore light decode of the state register.
    always_comb begin
        unlockLight  = (r_state == S_UNLOCKED) || (r_state == S_SET);
        errorLight   = (r_state == S_ERROR);
        warningLight = (r_state == S_LOCKED);
    end

    assign failCount  = r_fail;
    assign entryIndex = r_idx;

endmodule

// File: doc/param_password_lock.md
# param_password_lock

Parametrised serial password lock that accepts one digit per `digitValid` strobe. It validates or sets a `LEN`-digit password stored in registers, and counts consecutive failures. After `MAX_FAILS` failures it locks down; only a streamed admin sequence releases it, or optionally a lockout timer. It replaces the fixed 4-digit, 4-bit lock as the top-level lock block and generalises digit width, length, attempt limit and admin code.

## Interface
- `DIGIT_W`, 4, bits per digit
- `LEN`, 4, digits per password (≥1)
- `MAX_FAILS`, 3, consecutive failed entries that trigger lockdown (≥1)
- `INIT_PW`, 0, `LEN*DIGIT_W`-bit password loaded on reset; first digit in MS slot
- `ADMIN_PW`, 16'h0129, `LEN*DIGIT_W`-bit admin sequence; first digit in MS slot (default 0,1,2,9)
- `LOCKOUT_CYCLES`, 1000, lockdown auto-release delay (used only with `LOCKOUT_TIMER_EN`)

Ports:
- `CLK`  in  1  clock; all state changes on rising edge
- `RST`  in  1  reset, synchronous, active-low
- `setMode`  in  1  1 = set new password, 0 = validate; sampled only with the first digit accepted in S_UNLOCKED
- `digitValid`  in  1  one-cycle strobe; `digit` is accepted on each edge where it is high
- `digit`  in  `DIGIT_W`  user digit; compared exactly, no range check
- `clear`  in  1  abort the current entry, or relock
- `unlockLight`  out  1  high in S_UNLOCKED
- `errorLight`  out  1  high in S_ERROR
- `warningLight`  out  1  high in S_LOCKED
- `failCount`  out  `$clog2(MAX_FAILS+1)`  consecutive failures
- `entryIndex`  out  `$clog2(LEN+1)`  digits accepted in the current sequence

## Operation
- Storage: `pw[LEN]`, `shadow[LEN]`, `mismatch` flag, `idx`, `failCount`, state register.
- Digit k (0-based) is compared with slot `[(LEN-1-k)*DIGIT_W +: DIGIT_W]`.
- Input priority: `RST` > `clear` > `digitValid`.
- S_IDLE:
  - All lights 0.
  - Digit → S_ENTER, `idx`=1, `mismatch`=(digit≠pw[0]).
  - `clear` has no effect.
- S_ENTER:
  - Each digit ORs its comparison into `mismatch`. There is no early exit on mismatch; all `LEN` digits are always consumed.
  - On the `LEN`-th digit, with the final digit's comparison included:
    - Match → S_UNLOCKED, `failCount`=0.
    - Else `failCount`+1. If it reaches `MAX_FAILS` → S_LOCKED, otherwise → S_ERROR.
  - `LEN`=1 judges on the first digit, directly from S_IDLE/S_ERROR.
  - `clear` → S_IDLE, `idx`=0; `failCount` is unchanged.
- S_ERROR:
  - `errorLight`=1.
  - Digit starts a new entry exactly as from S_IDLE.
  - `clear` → S_IDLE.
- S_UNLOCKED:
  - `unlockLight`=1.
  - Digit with `setMode`=1 → S_SET, `shadow[0]`=digit, `idx`=1.
  - Digit with `setMode`=0 is ignored.
  - `clear` → S_IDLE.
- S_SET:
  - `unlockLight`=1.
  - Digits fill `shadow`. On the `LEN`-th digit, `pw` is committed atomically from `shadow` plus that digit, then → S_IDLE.
  - `clear` → S_UNLOCKED with `pw` unchanged.
  - `setMode` is ignored.
- S_LOCKED:
  - `warningLight`=1.
  - Each digit is checked immediately against `ADMIN_PW[idx]`:
    - Match → `idx`+1.
    - Mismatch → `idx`=0. The mismatching digit is not re-evaluated as a first admin digit.
  - `idx` reaching `LEN` → S_IDLE, `failCount`=0, `idx`=0.
  - `clear` is ignored.
- `entryIndex` mirrors `idx`. It returns to 0 on every state change except S_IDLE→S_ENTER, S_UNLOCKED→S_SET, and a mismatch-free admin progression.

## Timing
- Reset values (edge with `RST`=0):
  - State S_IDLE; `pw`=`INIT_PW`.
  - `failCount`=0, `idx`=0, `mismatch`=0.
  - All lights 0; timer 0.
- Reset mid-entry, mid-set or mid-lockdown discards everything; a partial `shadow` is never committed.
- Lights are Moore decodes of the state register. They are valid in the cycle after the edge that accepts the final digit (latency 1 cycle from strobe to light).
- Back-to-back strobes are accepted every cycle with no gaps required. A strobe in the same cycle as `clear` is dropped.
- `failCount` saturates at `MAX_FAILS`.

## Configuration
- `LOCKOUT_TIMER_EN` defined:
  - A counter runs while in S_LOCKED.
  - After `LOCKOUT_CYCLES` cycles in S_LOCKED, the next edge → S_IDLE, `failCount`=0.
  - An admin completion on the same edge yields the same result.
  - The counter clears on leaving S_LOCKED.
- Undefined: no counter is synthesised; only the admin sequence leaves S_LOCKED.

## Test plan
- Reset, digits 0,0,0,0 → `unlockLight`=1 one cycle after the 4th strobe, `failCount`=0.
- From S_UNLOCKED, `setMode`=1, digits 3,7,1,5 → S_IDLE. Then 0,0,0,0 → `errorLight`=1; then 3,7,1,5 → `unlockLight`=1.
- Three wrong entries (1,1,1,1 ×3) → `errorLight` after the 1st and 2nd, `warningLight`=1 after the 3rd with `failCount`=3. Then 0,1,2,9 → all lights 0, `failCount`=0.
- In S_LOCKED, digits 0,1,5,0,1,2,9 → locked until the final 9, then S_IDLE.
- `clear` after the 2nd digit of a set sequence 4,4 → `unlockLight`=1, old password still unlocks. `RST` low mid-entry → all outputs 0, `pw`=`INIT_PW`.
- With `LOCKOUT_TIMER_EN`, `LOCKOUT_CYCLES`=10: lock, wait 10 cycles → `warningLight` drops on the following edge. Without the macro, `warningLight` stays high for 1000+ cycles.
